// File: rtl/int_to_float_arbiter_pkg.sv
// Shared constants and types for the int32 -> fp32 arbiter slice.
package int_to_float_arbiter_pkg;

  localparam int          FP32_EXP_BIAS = 127;
  localparam int          FP32_MANT_W   = 23;
  localparam int          FP32_EXP_W    = 8;
  localparam logic [31:0] FP32_ZERO     = 32'h0;

  // Field view of a single-precision value, MSB first.
  typedef struct packed {
    logic                   sign;
    logic [FP32_EXP_W-1:0]  exp;
    logic [FP32_MANT_W-1:0] mant;
  } fp32_t;

  // Magnitude of a two's-complement int32 as unsigned; 0x80000000 maps to 2^31.
  function automatic logic [31:0] abs_int32(input logic [31:0] a);
    return a[31] ? (~a + 32'd1) : a;
  endfunction

endpackage

// File: rtl/int_to_float_arbiter_if.sv
// Request lanes plus result channel of the shared converter.
interface int_to_float_arbiter_if #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*32-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               out_valid;
  logic [31:0]        out_data;
  logic [ID_W-1:0]    out_id;
  logic               out_ready;

  // Producers and result consumer.
  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id
  );

  // The shared converter.
  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id
  );
endinterface

// File: rtl/int_to_float_arbiter_core.sv
// Combinational int32 -> IEEE-754 single conversion, truncating toward zero.
module int_to_float_core
  import int_to_float_arbiter_pkg::*;
(
  input  logic [31:0] i_int,
  output logic [31:0] o_float
);

  logic                   w_sign;
  logic [31:0]            w_mag;
  logic [4:0]             w_lead;
  logic [FP32_MANT_W-1:0] w_mant;
  fp32_t                  w_fp;

  assign w_sign = i_int[31];
  assign w_mag  = abs_int32(i_int);

  // Leading-one detect: the highest set bit wins because it is assigned last.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_lead = '0;
    for (int b = 0; b < 32; b++) begin
      if (w_mag[b]) w_lead = 5'(b);
    end
  end

  // Left-align the leading one at bit 31, keep the 23 bits below it; lower bits are dropped.
  assign w_mant = FP32_MANT_W'((w_mag << (5'd31 - w_lead)) >> 8);

  // Pack the fields; zero has no leading one and maps to +0.
  always_comb begin
    w_fp.sign = w_sign;
    w_fp.exp  = FP32_EXP_W'(FP32_EXP_BIAS) + FP32_EXP_W'(w_lead);
    w_fp.mant = w_mant;
    o_float   = (w_mag == 32'd0) ? FP32_ZERO : w_fp;
  end

endmodule

// File: rtl/int_to_float_arbiter.sv
// Round-robin arbiter feeding one shared int->float converter through a
// two-stage valid/ready pipeline; results carry the requester index.
module int_to_float_arbiter
  import int_to_float_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  int_to_float_arbiter_if.slave  bus,
  output logic                   busy,
  output logic [31:0]            conv_count
);

  localparam int SUM_W = ID_W + 1;

  logic [ID_W-1:0]  r_ptr;
  logic             r_s1_valid;
  logic [31:0]      r_s1_data;
  logic [ID_W-1:0]  r_s1_id;
  logic             r_s2_valid;
  logic [31:0]      r_s2_data;
  logic [ID_W-1:0]  r_s2_id;
  logic [31:0]      r_conv_count;

  logic             w_adv1;
  logic             w_adv2;
  logic [NREQ-1:0]  w_rot;
  logic             w_grant_vld;
  logic [ID_W-1:0]  w_off;
  logic [SUM_W-1:0] w_sum;
  logic [ID_W-1:0]  w_winner;
  logic             w_grant;
  logic [NREQ-1:0]  w_req_ready;
  logic [31:0]      w_sel_data;
  logic [31:0]      w_conv;

  // Stage 2 frees when empty or drained; stage 1 frees when empty or moving on.
  assign w_adv2 = !r_s2_valid || bus.out_ready;
  assign w_adv1 = !r_s1_valid || w_adv2;

  // Rotate requests so bit 0 is the lane the pointer currently favours.
  assign w_rot = NREQ'({bus.req_valid, bus.req_valid} >> r_ptr);

  // Lowest set bit of the rotated vector is the round-robin winner offset.
  always_comb begin
    w_grant_vld = 1'b0;
    w_off       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_grant_vld = 1'b1;
        w_off       = ID_W'(k);
      end
    end
  end

  // Undo the rotation: winner = (ptr + offset) mod NREQ.
  assign w_sum    = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_winner = (w_sum >= SUM_W'(NREQ)) ? ID_W'(w_sum - SUM_W'(NREQ)) : ID_W'(w_sum);
  assign w_grant  = rst && w_adv1 && w_grant_vld;

  // One-hot ready on the winner; silent while in reset or while stage 1 is stuck.
  always_comb begin
    w_req_ready = '0;
    if (w_grant) w_req_ready[w_winner] = 1'b1;
  end

  // Operand of the winning lane.
  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_winner == ID_W'(k)) w_sel_data = bus.req_data[32*k +: 32];
    end
  end

  // Round-robin pointer moves just past each winner.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: clocked state is written with <= so every register samples pre-edge values.
    if (!rst) begin
      r_ptr <= '0;
    end else if (w_grant) begin
      r_ptr <= (w_winner == ID_W'(NREQ - 1)) ? '0 : w_winner + 1'b1;
    end
  end

  // Stage 1: granted operand and its tag.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the data/tag registers are reset too, so outputs read 0 after reset rather than X.
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_id    <= '0;
    end else if (w_adv1) begin
      r_s1_valid <= w_grant;
      if (w_grant) begin
        r_s1_data <= w_sel_data;
        r_s1_id   <= w_winner;
      end
    end
  end

  int_to_float_core u_core (
    .i_int   (r_s1_data),
    .o_float (w_conv)
  );

  // Stage 2: converted result; held unchanged while the consumer stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_id    <= '0;
    end else if (w_adv2) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= w_conv;
        r_s2_id   <= r_s1_id;
      end
    end
  end

  // Count results taken by the consumer; wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_conv_count <= '0;
    end else if (r_s2_valid && bus.out_ready) begin
      r_conv_count <= r_conv_count + 32'd1;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.out_valid = r_s2_valid;
  assign bus.out_data  = r_s2_data;
  assign bus.out_id    = r_s2_id;
  assign busy          = r_s1_valid || r_s2_valid;
  assign conv_count    = r_conv_count;

endmodule
